// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IM/DM requester handshakes plus the unified-memory bus.
// slave is the arbiter side; master is the requester/memory side.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH    = 12,
   parameter int DATA_WIDTH    = 32,
   parameter int IM_ADDR_WIDTH = 10
);
   logic                     im_req;
   logic                     im_write;
   logic [IM_ADDR_WIDTH-1:0] im_address;
   logic [DATA_WIDTH-1:0]    im_wdata;
   logic [DATA_WIDTH-1:0]    im_rdata;
   logic                     im_ready;
   logic                     dm_req;
   logic                     dm_write;
   logic [ADDR_WIDTH-1:0]    dm_address;
   logic [DATA_WIDTH-1:0]    dm_wdata;
   logic [DATA_WIDTH-1:0]    dm_rdata;
   logic                     dm_ready;
   logic                     mem_enable;
   logic                     mem_read;
   logic                     mem_write;
   logic [ADDR_WIDTH-1:0]    mem_address;
   logic [DATA_WIDTH-1:0]    mem_in;
   logic [DATA_WIDTH-1:0]    mem_out;
   logic                     busy;
   logic                     grant_dm;

   modport slave (
      input  im_req, im_write, im_address, im_wdata,
      input  dm_req, dm_write, dm_address, dm_wdata, mem_out,
      output im_rdata, im_ready, dm_rdata, dm_ready,
      output mem_enable, mem_read, mem_write, mem_address, mem_in, busy, grant_dm
   );

   modport master (
      output im_req, im_write, im_address, im_wdata,
      output dm_req, dm_write, dm_address, dm_wdata, mem_out,
      input  im_rdata, im_ready, dm_rdata, dm_ready,
      input  mem_enable, mem_read, mem_write, mem_address, mem_in, busy, grant_dm
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between IM and DM requesters,
// DM-first with a starvation guard that forces an IM grant after STARVE_LIMIT losses.
module mem_arbiter #(
   parameter int                    ADDR_WIDTH    = 12,
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    IM_ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] IM_BASE       = 12'h000,
   parameter int                    WAIT_CYCLES   = 1,
   parameter int                    STARVE_LIMIT  = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            wait_q, wait_d, starve_q, starve_d;
   logic                  grant_dm_q, grant_dm_d, en_q, en_d, rd_q, rd_d, wr_q, wr_d;
   logic                  im_rdy_q, im_rdy_d, dm_rdy_q, dm_rdy_d, busy_q;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] in_q, in_d, im_rd_q, im_rd_d, dm_rd_q, dm_rd_d;
   logic                  take_dm, wr_sel;

   // IM only wins a contested cycle once it has lost STARVE_LIMIT times in a row
   assign take_dm = bus.dm_req && !(bus.im_req && starve_q == 4'(STARVE_LIMIT));
   assign wr_sel  = take_dm ? bus.dm_write : bus.im_write;

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      starve_d   = starve_q;
      grant_dm_d = grant_dm_q;
      en_d       = en_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      in_d       = in_q;
      im_rd_d    = im_rd_q;
      dm_rd_d    = dm_rd_q;
      im_rdy_d   = 1'b0;
      dm_rdy_d   = 1'b0;
      case (state_q)
         IDLE: if (bus.im_req || bus.dm_req) begin
            state_d    = ACCESS;
            wait_d     = 4'(WAIT_CYCLES - 1);
            grant_dm_d = take_dm;
            starve_d   = take_dm ? starve_q + 4'(bus.im_req) : 4'd0;
            en_d       = 1'b1;
            rd_d       = !wr_sel;
            wr_d       = wr_sel;
            addr_d     = take_dm ? bus.dm_address : IM_BASE + ADDR_WIDTH'(bus.im_address);
            in_d       = take_dm ? bus.dm_wdata : bus.im_wdata;
         end
         ACCESS: if (wait_q == 4'd0) begin
            state_d  = RESP;
            im_rd_d  = (rd_q && !grant_dm_q) ? bus.mem_out : im_rd_q;
            dm_rd_d  = (rd_q && grant_dm_q) ? bus.mem_out : dm_rd_q;
            im_rdy_d = !grant_dm_q;
            dm_rdy_d = grant_dm_q;
            en_d     = 1'b0;
            rd_d     = 1'b0;
            wr_d     = 1'b0;
            addr_d   = '0;
            in_d     = '0;
         end else begin
            wait_d = wait_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         starve_q   <= '0;
         grant_dm_q <= 1'b0;
         en_q       <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         in_q       <= '0;
         im_rd_q    <= '0;
         dm_rd_q    <= '0;
         im_rdy_q   <= 1'b0;
         dm_rdy_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         starve_q   <= starve_d;
         grant_dm_q <= grant_dm_d;
         en_q       <= en_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         in_q       <= in_d;
         im_rd_q    <= im_rd_d;
         dm_rd_q    <= dm_rd_d;
         im_rdy_q   <= im_rdy_d;
         dm_rdy_q   <= dm_rdy_d;
         busy_q     <= state_d != IDLE;
      end
   end

   assign bus.mem_enable  = en_q;
   assign bus.mem_read    = rd_q;
   assign bus.mem_write   = wr_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_in      = in_q;
   assign bus.im_rdata    = im_rd_q;
   assign bus.dm_rdata    = dm_rd_q;
   assign bus.im_ready    = im_rdy_q;
   assign bus.dm_ready    = dm_rdy_q;
   assign bus.busy        = busy_q;
   assign bus.grant_dm    = grant_dm_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two configurations of mem_arbiter checked every cycle against a
// transaction-schedule model, plus hand-computed expectations for the directed cases.
module tb_mem_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0, done_cnt = 0;

   typedef struct packed { logic wr; logic [11:0] addr; logic [31:0] data; } tx_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // memory contents; reads outside the final access cycle see junk instead
   function automatic logic [31:0] mem_f(input logic [11:0] a);
      return a == 12'h405 ? 32'hDEADBEEF : {20'hA5A50, a};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : c
      localparam int          W    = g ? 3 : 1;
      localparam logic [11:0] BASE = g ? 12'hFFE : 12'h400;
      localparam int          SL   = g ? 2 : 4;

      logic rst_n = 1'b1;
      mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .IM_ADDR_WIDTH(10)) bus ();
      mem_arbiter #(
         .ADDR_WIDTH(12), .DATA_WIDTH(32), .IM_ADDR_WIDTH(10),
         .IM_BASE(BASE), .WAIT_CYCLES(W), .STARVE_LIMIT(SL)
      ) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

      tx_t         im_q[$], dm_q[$];
      int          p = 0, tg = 0, starve = 0;
      logic        active = 1'b0, t_dm = 1'b0, t_wr = 1'b0, last_dm = 1'b0, acc, rsp;
      logic [11:0] t_addr = '0;
      logic [31:0] t_data = '0, erd_im = '0, erd_dm = '0;
      int          en_cnt, imr_cnt, dmr_cnt, both_cnt, en_p, rdy_p;
      logic [11:0] last_addr;
      logic [31:0] last_in;
      logic        wr_seen;
      logic        grants[$];

      task automatic clr();
         en_cnt = 0; imr_cnt = 0; dmr_cnt = 0; both_cnt = 0; en_p = 0; rdy_p = 0;
         last_addr = '0; last_in = '0; wr_seen = 1'b0;
         grants.delete();
      endtask

      task automatic push(input logic dm, input logic wr, input logic [11:0] a, input logic [31:0] d);
         if (dm) dm_q.push_back({wr, a, d});
         else im_q.push_back({wr, a, d});
      endtask

      task automatic settle();
         for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (im_q.size() == 0 && dm_q.size() == 0 && !(active && p <= tg + W + 1)) return;
         end
         checks++;
         errors++;
         $display("FAIL c%0d_timeout requests still pending after 300 cycles, want idle", g);
      endtask

      task automatic seq(input int n, output logic [9:0] s);
         s = '0;
         for (int i = 0; i < n; i++) s = {s[8:0], i < grants.size() ? grants[i] : 1'b0};
      endtask

      // model, requesters and memory: all act at the falling edge, away from the DUT's edge
      initial begin : loop
         forever begin
            @(negedge clk);
            p++;
            if (!rst_n) begin
               im_q.delete(); dm_q.delete();
               active = 1'b0; starve = 0; erd_im = '0; erd_dm = '0; last_dm = 1'b0;
            end
            acc = active && p > tg && p <= tg + W;
            rsp = active && p == tg + W + 1;
            if (rsp && !t_wr) begin
               if (t_dm) erd_dm = mem_f(t_addr);
               else erd_im = mem_f(t_addr);
            end
            chk($sformatf("c%0d_mem p%0d", g, p),
                {bus.mem_enable, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_in},
                {acc, acc && !t_wr, acc && t_wr, acc ? t_addr : 12'h0, acc ? t_data : 32'h0});
            chk($sformatf("c%0d_ctl p%0d", g, p),
                {bus.im_ready, bus.dm_ready, bus.busy, bus.grant_dm},
                {rsp && !t_dm, rsp && t_dm, acc || rsp, last_dm});
            chk($sformatf("c%0d_rdata p%0d", g, p), {bus.im_rdata, bus.dm_rdata}, {erd_im, erd_dm});
            if (bus.mem_enable) begin
               if (en_cnt == 0) en_p = p;
               en_cnt++;
               last_addr = bus.mem_address;
               last_in   = bus.mem_in;
               wr_seen   = wr_seen | bus.mem_write;
            end
            if (bus.im_ready) begin imr_cnt++; rdy_p = p; grants.push_back(1'b0); end
            if (bus.dm_ready) begin dmr_cnt++; rdy_p = p; grants.push_back(1'b1); end
            if (bus.im_ready && bus.dm_ready) both_cnt++;
            if (rst_n && bus.im_ready) void'(im_q.pop_front());
            if (rst_n && bus.dm_ready) void'(dm_q.pop_front());
            bus.im_req     = im_q.size() > 0;
            bus.im_write   = im_q.size() > 0 ? im_q[0].wr : 1'b0;
            bus.im_address = im_q.size() > 0 ? im_q[0].addr[9:0] : 10'h0;
            bus.im_wdata   = im_q.size() > 0 ? im_q[0].data : 32'h0;
            bus.dm_req     = dm_q.size() > 0;
            bus.dm_write   = dm_q.size() > 0 ? dm_q[0].wr : 1'b0;
            bus.dm_address = dm_q.size() > 0 ? dm_q[0].addr : 12'h0;
            bus.dm_wdata   = dm_q.size() > 0 ? dm_q[0].data : 32'h0;
            if (rst_n && !(active && p <= tg + W + 1) && (im_q.size() > 0 || dm_q.size() > 0)) begin
               t_dm = dm_q.size() > 0 && !(im_q.size() > 0 && starve == SL);
               if (t_dm) begin
                  if (im_q.size() > 0) starve = starve + 1;
                  t_wr = dm_q[0].wr; t_addr = dm_q[0].addr; t_data = dm_q[0].data;
               end else begin
                  starve = 0;
                  t_wr = im_q[0].wr; t_data = im_q[0].data;
                  t_addr = 12'((int'(BASE) + int'(im_q[0].addr)) % 4096);
               end
               active = 1'b1; tg = p; last_dm = t_dm;
            end
            bus.mem_out = (active && p == tg + W && !t_wr) ? mem_f(bus.mem_address) : 32'hBAD00000 | 32'(p);
         end
      end

      initial begin : scen
         logic [9:0] s;
         rst_n = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("c%0d_rst_ctl", g),
             {bus.mem_enable, bus.mem_read, bus.mem_write, bus.busy, bus.grant_dm, bus.im_ready, bus.dm_ready}, 64'd0);
         chk($sformatf("c%0d_rst_data", g), {bus.im_rdata, bus.dm_rdata}, 64'd0);
         chk($sformatf("c%0d_rst_bus", g), {bus.mem_address, bus.mem_in}, 64'd0);
         #1 rst_n = 1'b1;
         @(posedge clk);
         #1;
         if (g == 0) begin
            clr(); push(1'b0, 1'b0, 12'h005, 32'h0); settle();
            chk("c0_im_addr", last_addr, 12'h405);
            chk("c0_im_en_cycles", en_cnt, 1);
            chk("c0_im_latency", rdy_p - en_p, 1);
            chk("c0_im_ready_cnt", imr_cnt, 1);
            chk("c0_im_rdata", bus.im_rdata, 32'hDEADBEEF);
            clr(); push(1'b1, 1'b0, 12'h010, 32'h0); settle();
            chk("c0_dm_rdata", bus.dm_rdata, 32'hA5A50010);
            clr(); push(1'b1, 1'b1, 12'h0FF, 32'h12345678); settle();
            chk("c0_dm_write", {wr_seen, last_addr, last_in}, {1'b1, 12'h0FF, 32'h12345678});
            chk("c0_dm_ready_cnt", dmr_cnt, 1);
            chk("c0_dm_rdata_kept", bus.dm_rdata, 32'hA5A50010);
            chk("c0_im_rdata_kept", bus.im_rdata, 32'hDEADBEEF);
            clr();
            for (int i = 0; i < 8; i++) push(1'b1, 1'b0, 12'h100 + 12'(i), 32'h0);
            for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 12'(i), 32'h0);
            settle();
            seq(10, s);
            chk("c0_grant_seq", s, 10'b1111011110);
            chk("c0_both_ready", both_cnt, 0);
            chk("c0_ready_cnts", {imr_cnt, dmr_cnt}, {32'd3, 32'd8});
         end else begin
            clr(); push(1'b1, 1'b0, 12'h020, 32'h0); settle();
            chk("c1_dm_en_cycles", en_cnt, 3);
            chk("c1_dm_rdata", bus.dm_rdata, 32'hA5A50020);
            chk("c1_dm_ready_cnt", dmr_cnt, 1);
            clr(); push(1'b0, 1'b0, 12'h003, 32'h0); settle();
            chk("c1_im_wrap_addr", last_addr, 12'h001);
            chk("c1_im_rdata", bus.im_rdata, 32'hA5A50001);
            clr();
            for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 12'h030 + 12'(i), 32'h0);
            for (int i = 0; i < 2; i++) push(1'b0, 1'b0, 12'(4 + i), 32'h0);
            settle();
            seq(5, s);
            chk("c1_grant_seq", s, 10'b0000011010);
            chk("c1_both_ready", both_cnt, 0);
            clr(); push(1'b1, 1'b1, 12'h0AA, 32'hCAFEF00D);
            @(posedge clk);
            #1;
            chk("c1_pre_reset_access", {bus.mem_enable, bus.mem_write}, 2'b11);
            rst_n = 1'b0;
            #1;
            chk("c1_reset_abort", {bus.mem_enable, bus.mem_write, bus.busy}, 3'b000);
            clr();
            repeat (2) @(posedge clk);
            #2 rst_n = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            chk("c1_no_ready_after_reset", dmr_cnt, 0);
            chk("c1_no_access_after_reset", en_cnt, 0);
         end
         done_cnt++;
      end
   end

   initial begin
      for (int i = 0; i < 5000 && done_cnt < 2; i++) @(posedge clk);
      if (done_cnt < 2) begin
         checks++;
         errors++;
         $display("FAIL scenarios_timeout finished %0d want 2", done_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
